// File: rtl/sha3_padder_if.sv
// Stream bundle between a byte source, the SHA-3 padder and the keccak core.
// Latency: n/a (wires only).
// Backpressure: in_ready throttles the byte side, out_ready throttles the block side.
//
// Ports (signals):
//   in_byte/in_valid/in_last/in_flush -> padder   message bytes and end markers
//   in_ready                          <- padder   byte/flush accepted when high
//   out_block/out_valid/out_last      <- padder   R-bit rate block, byte 0 in MSBs
//   out_ready                         -> padder   consumer accepts block
interface sha3_padder_if #(
  parameter int R = 1344
);
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_last;
  logic         in_flush;
  logic         in_ready;
  logic [R-1:0] out_block;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;

  // master: byte producer / block consumer side
  modport master (
    output in_byte, in_valid, in_last, in_flush, out_ready,
    input  in_ready, out_block, out_valid, out_last
  );

  // slave: the padder itself
  modport slave (
    input  in_byte, in_valid, in_last, in_flush, out_ready,
    output in_ready, out_block, out_valid, out_last
  );
endinterface

// File: rtl/sha3_padder.sv
// Packs message bytes into r-bit rate blocks and applies SHA-3 01 + pad10*1 padding.
// Latency: block valid 1 cycle after the accept of the final byte or flush.
// Backpressure: in_ready low while a block is held; block held stable until out_ready.
//
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    sha3_padder_if.slave (byte input stream, block output stream)
module sha3_padder #(
  parameter int d = 128,
  parameter int r = 1600 - 2 * d
) (
  input  logic          clk,
  input  logic          reset,
  sha3_padder_if.slave  bus
);

  localparam int NB = r / 8;
  localparam int IW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       w_idx_nxt;
  logic                r_pad_pending;
  logic                w_pad_pending_nxt;
  logic                r_out_last;
  logic                w_out_last_nxt;
  // Byte 0 is the leftmost element, so it lands in the MSBs of out_block.
  logic [0:NB-1][7:0]  r_buf;
  logic [0:NB-1][7:0]  w_buf_nxt;
  logic                w_at_end;
  logic                w_do_pad;
  logic [IW:0]         w_pad_start;

  assign w_at_end = (r_idx == IW'(NB - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_pad_pending_nxt = r_pad_pending;
    w_out_last_nxt    = r_out_last;
    w_buf_nxt         = r_buf;
    w_do_pad          = 1'b0;
    w_pad_start       = '0;

    case (r_state)
      IDLE: begin
        w_state_nxt = FILL;
      end

      FILL: begin
        // A byte always wins over a simultaneous flush.
        if (bus.in_valid) begin
          w_buf_nxt[r_idx] = bus.in_byte;
          if (!bus.in_last && !w_at_end) begin
            w_idx_nxt = r_idx + 1'b1;
          end else begin
            w_state_nxt = EMIT;
            if (bus.in_last && !w_at_end) begin
              w_do_pad       = 1'b1;
              w_pad_start    = {1'b0, r_idx} + 1'b1;
              w_out_last_nxt = 1'b1;
            end else begin
              // Full block; a last byte here leaves no room for padding,
              // so a separate all-pad block follows.
              w_out_last_nxt    = 1'b0;
              w_pad_pending_nxt = bus.in_last;
            end
          end
        end else if (bus.in_flush) begin
          w_do_pad       = 1'b1;
          w_pad_start    = {1'b0, r_idx};
          w_out_last_nxt = 1'b1;
          w_state_nxt    = EMIT;
        end
      end

      EMIT: begin
        if (bus.out_ready) begin
          w_buf_nxt = '0;
          if (r_pad_pending) begin
            w_do_pad          = 1'b1;
            w_pad_start       = '0;
            w_out_last_nxt    = 1'b1;
            w_pad_pending_nxt = 1'b0;
          end else begin
            w_idx_nxt      = '0;
            w_out_last_nxt = 1'b0;
            w_state_nxt    = FILL;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Pad slots p..NB-1: 0x60 at p, 0x01 at NB-1, 0x61 when they coincide.
    if (w_do_pad) begin
      for (int j = 0; j < NB; j++) begin
        if (j >= int'(w_pad_start)) begin
          w_buf_nxt[j] = ((j == int'(w_pad_start)) ? 8'h60 : 8'h00) |
                         ((j == NB - 1)            ? 8'h01 : 8'h00);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx         <= '0;
      r_pad_pending <= 1'b0;
      r_out_last    <= 1'b0;
      r_buf         <= '0;
    end else begin
      r_idx         <= w_idx_nxt;
      r_pad_pending <= w_pad_pending_nxt;
      r_out_last    <= w_out_last_nxt;
      r_buf         <= w_buf_nxt;
    end
  end

  // Handshake outputs decode the state register only: no path from out_ready.
  assign bus.in_ready  = (r_state == FILL);
  assign bus.out_valid = (r_state == EMIT);
  assign bus.out_block = r_buf;
  assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_sha3_padder.sv
// Directed bench for sha3_padder at d=128 (168-byte blocks).
// Latency: checks block valid 1 cycle after final accept.
// Backpressure: stalls out_ready and checks hold/stability of the block.
module tb_sha3_padder;
  localparam int R  = 1344;
  localparam int NB = 168;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sha3_padder_if #(.R(R)) bus();

  sha3_padder #(.d(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int errors   = 0;
  int hs_count = 0;

  always @(posedge clk) begin
    if (bus.out_valid && bus.out_ready) hs_count <= hs_count + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [R-1:0] setb(input logic [R-1:0] blk, input int i, input logic [7:0] v);
    logic [R-1:0] t;
    t = blk;
    t[R-8*(i+1) +: 8] = v;
    return t;
  endfunction

  function automatic logic [7:0] getb(input logic [R-1:0] blk, input int i);
    return blk[R-8*(i+1) +: 8];
  endfunction

  function automatic int first_diff(input logic [R-1:0] a, input logic [R-1:0] b);
    for (int i = 0; i < NB; i++) begin
      if (getb(a, i) !== getb(b, i)) return i;
    end
    return -1;
  endfunction

  // Present one byte and hold it until accepted; returns at posedge+1 after accept.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    while (!bus.in_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL send_byte: in_ready never rose (byte %h)", b);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Wait for a block, capture it, then consume it with one out_ready pulse.
  task automatic get_block(output logic [R-1:0] blk, output logic lst);
    int n;
    n = 0;
    while (!bus.out_valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.out_valid) begin
      errors++;
      $display("FAIL get_block: out_valid never rose");
    end
    blk = bus.out_block;
    lst = bus.out_last;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready  !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_last  !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", bus.out_last); end
    checks++; if (bus.out_block !== '0)   begin errors++; $display("FAIL rst_out_block: nonzero block, slot0 %h", getb(bus.out_block, 0)); end
    reset = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_release_cycle: in_ready got %b want 0", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_fill: in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_abc;
    logic [R-1:0] exp, got;
    logic lst;
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL abc_latency: out_valid got %b want 1", bus.out_valid); end
    exp = '0;
    exp = setb(exp, 0, 8'h61);
    exp = setb(exp, 1, 8'h62);
    exp = setb(exp, 2, 8'h63);
    exp = setb(exp, 3, 8'h60);
    exp = setb(exp, 167, 8'h01);
    get_block(got, lst);
    checks++; if (got !== exp) begin errors++; $display("FAIL abc_block: slot %0d got %h want %h", first_diff(got, exp), getb(got, first_diff(got, exp)), getb(exp, first_diff(got, exp))); end
    checks++; if (lst !== 1'b1) begin errors++; $display("FAIL abc_last: got %b want 1", lst); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abc_ready_after: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_167;
    logic [R-1:0] exp, got;
    logic lst;
    for (int i = 0; i < 167; i++) send_byte(8'hAA, (i == 166));
    exp = '0;
    for (int i = 0; i < 167; i++) exp = setb(exp, i, 8'hAA);
    exp = setb(exp, 167, 8'h61);
    get_block(got, lst);
    checks++; if (got !== exp) begin errors++; $display("FAIL b167_block: slot %0d got %h want %h", first_diff(got, exp), getb(got, first_diff(got, exp)), getb(exp, first_diff(got, exp))); end
    checks++; if (lst !== 1'b1) begin errors++; $display("FAIL b167_last: got %b want 1", lst); end
  endtask

  task automatic test_168;
    logic [R-1:0] exp1, exp2, got;
    logic lst;
    int hs0;
    hs0 = hs_count;
    for (int i = 0; i < 168; i++) send_byte(8'h55, (i == 167));
    exp1 = '0;
    for (int i = 0; i < 168; i++) exp1 = setb(exp1, i, 8'h55);
    exp2 = '0;
    exp2 = setb(exp2, 0, 8'h60);
    exp2 = setb(exp2, 167, 8'h01);
    get_block(got, lst);
    checks++; if (got !== exp1) begin errors++; $display("FAIL b168_block1: slot %0d got %h want %h", first_diff(got, exp1), getb(got, first_diff(got, exp1)), getb(exp1, first_diff(got, exp1))); end
    checks++; if (lst !== 1'b0) begin errors++; $display("FAIL b168_last1: got %b want 0", lst); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b168_pad_next: out_valid got %b want 1", bus.out_valid); end
    get_block(got, lst);
    checks++; if (got !== exp2) begin errors++; $display("FAIL b168_block2: slot %0d got %h want %h", first_diff(got, exp2), getb(got, first_diff(got, exp2)), getb(exp2, first_diff(got, exp2))); end
    checks++; if (lst !== 1'b1) begin errors++; $display("FAIL b168_last2: got %b want 1", lst); end
    checks++; if (hs_count - hs0 !== 2) begin errors++; $display("FAIL b168_handshakes: got %0d want 2", hs_count - hs0); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b168_ready_after: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_flush;
    logic [R-1:0] exp, got;
    logic lst;
    bus.in_flush = 1'b1;
    @(posedge clk); #1;
    bus.in_flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_latency: out_valid got %b want 1", bus.out_valid); end
    exp = '0;
    exp = setb(exp, 0, 8'h60);
    exp = setb(exp, 167, 8'h01);
    get_block(got, lst);
    checks++; if (got !== exp) begin errors++; $display("FAIL flush_block: slot %0d got %h want %h", first_diff(got, exp), getb(got, first_diff(got, exp)), getb(exp, first_diff(got, exp))); end
    checks++; if (lst !== 1'b1) begin errors++; $display("FAIL flush_last: got %b want 1", lst); end
  endtask

  task automatic test_backpressure;
    logic [R-1:0] exp1, exp2, got;
    logic lst;
    send_byte(8'h10, 1'b1);
    exp1 = '0;
    exp1 = setb(exp1, 0, 8'h10);
    exp1 = setb(exp1, 1, 8'h60);
    exp1 = setb(exp1, 167, 8'h01);
    // Offer the next message's byte while the consumer stalls.
    bus.in_byte  = 8'h7E;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_block !== exp1) begin errors++; $display("FAIL stall_block cyc %0d: slot %0d got %h want %h", c, first_diff(bus.out_block, exp1), getb(bus.out_block, first_diff(bus.out_block, exp1)), getb(exp1, first_diff(bus.out_block, exp1))); end
      checks++; if (bus.out_last  !== 1'b1) begin errors++; $display("FAIL stall_last cyc %0d: got %b want 1", c, bus.out_last); end
      checks++; if (bus.in_ready  !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc %0d: got %b want 0", c, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d: got %b want 1", c, bus.out_valid); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: in_ready got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    exp2 = '0;
    exp2 = setb(exp2, 0, 8'h7E);
    exp2 = setb(exp2, 1, 8'h60);
    exp2 = setb(exp2, 167, 8'h01);
    get_block(got, lst);
    checks++; if (got !== exp2) begin errors++; $display("FAIL stall_next_block: slot %0d got %h want %h", first_diff(got, exp2), getb(got, first_diff(got, exp2)), getb(exp2, first_diff(got, exp2))); end
    checks++; if (lst !== 1'b1) begin errors++; $display("FAIL stall_next_last: got %b want 1", lst); end
  endtask

  task automatic test_precedence;
    logic [R-1:0] exp, got;
    logic lst;
    bus.in_flush = 1'b1;
    send_byte(8'h33, 1'b1);
    bus.in_flush = 1'b0;
    exp = '0;
    exp = setb(exp, 0, 8'h33);
    exp = setb(exp, 1, 8'h60);
    exp = setb(exp, 167, 8'h01);
    get_block(got, lst);
    checks++; if (got !== exp) begin errors++; $display("FAIL prec_block: slot %0d got %h want %h", first_diff(got, exp), getb(got, first_diff(got, exp)), getb(exp, first_diff(got, exp))); end
    checks++; if (lst !== 1'b1) begin errors++; $display("FAIL prec_last: got %b want 1", lst); end
  endtask

  task automatic test_mid_reset;
    logic [R-1:0] exp, got;
    logic lst;
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h11 + 8'(i), 1'b0);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_fill_valid byte %0d: got %b want 0", i, bus.out_valid); end
    end
    reset = 1'b0;
    #1;
    checks++; if (bus.in_ready  !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b want 0", bus.out_valid); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++; if (bus.in_ready  !== 1'b0) begin errors++; $display("FAIL mid_release_cycle: in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_release_valid: got %b want 0", bus.out_valid); end
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_refill: in_ready got %b want 1", bus.in_ready); end
    send_byte(8'h42, 1'b1);
    exp = '0;
    exp = setb(exp, 0, 8'h42);
    exp = setb(exp, 1, 8'h60);
    exp = setb(exp, 167, 8'h01);
    get_block(got, lst);
    checks++; if (got !== exp) begin errors++; $display("FAIL mid_next_block: slot %0d got %h want %h", first_diff(got, exp), getb(got, first_diff(got, exp)), getb(exp, first_diff(got, exp))); end
    checks++; if (lst !== 1'b1) begin errors++; $display("FAIL mid_next_last: got %b want 1", lst); end
  endtask

  initial begin
    bus.in_byte   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_flush  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_abc();
    test_167();
    test_168();
    test_flush();
    test_backpressure();
    test_precedence();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha3_padder.md
# sha3_padder

Byte-stream front end for the `keccak` core. It packs incoming message bytes into R-bit rate blocks and applies SHA-3 domain-separation padding (01 suffix plus pad10*1) in the bit order the core expects. It presents each finished block on a valid/ready handshake to the core's `message` input, and flags the final block of every message.

## Interface

Parameters:

- `d`, 128: digest width; sets the rate.
- `r`, 1600-2*d: rate in bits; derived, do not override. `NB` = r/8 bytes per block (168 at default).

Ports:

- `clk`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_byte`  in  8: message byte.
- `in_valid`  in  1: `in_byte` valid.
- `in_last`  in  1: qualifies `in_valid`; this byte ends the message.
- `in_flush`  in  1: ends the message with no byte; sampled only when `in_valid`=0.
- `in_ready`  out  1: byte/flush accepted this cycle when high.
- `out_block`  out  r: packed block; byte i at `out_block[r-8*(i+1) +: 8]`, so byte 0 is in the MSBs.
- `out_valid`  out  1: `out_block` valid.
- `out_last`  out  1: block is the final (padded) block of the message.
- `out_ready`  in  1: consumer accepts the block.

## Operation

States:

- **IDLE**: entered on reset. Moves to FILL unconditionally on the first clock after reset releases.
- **FILL**: `in_ready`=1. Byte index `idx` runs 0..NB-1 and is `$clog2(NB)` bits wide.
- **EMIT**: `out_valid`=1 and `in_ready`=0.

Byte accept (FILL with `in_valid` high):

- Write `in_byte` to slot `idx`, unmodified.
- Not last, `idx`<NB-1: `idx`++.
- Not last, `idx`=NB-1: go to EMIT with `out_last`=0.
- Last, `idx`<NB-1: pad slots `idx`+1..NB-1, then go to EMIT with `out_last`=1.
- Last, `idx`=NB-1: block is full. Go to EMIT with `out_last`=0 and set `pad_pending`.

Flush (FILL with `in_valid`=0 and `in_flush`=1):

- Pad slots `idx`..NB-1 and go to EMIT with `out_last`=1.
- If `idx`=0, this produces an all-pad block. This covers the empty message, and the case where the upstream ended on an exact block boundary without asserting `in_last`.

Padding rule over pad slots p..NB-1:

- Slot p gets 8'h60.
- Slot NB-1 gets 8'h01.
- Slots between get 8'h00.
- If p = NB-1, that slot gets 8'h61.

EMIT with `out_ready` high:

- If `pad_pending` is set: load an all-pad block (slot 0 = 60, slot NB-1 = 01), set `out_last`=1, clear `pad_pending`, stay in EMIT.
- Otherwise: clear the buffer, set `idx`=0, `out_last`=0, go to FILL.

Boundary rules:

- `in_valid` and `in_flush` together: the byte (with its `in_last`) is used and the flush is ignored.
- `in_last` is ignored when `in_valid`=0.
- Inputs are ignored when `in_ready`=0. Upstream must hold its byte.
- `out_block` and `out_last` are stable while `out_valid` is high and `out_ready` is low.
- Reset mid-operation: the partial block is discarded and the state returns to IDLE. There is no partial output.

## Timing

- Reset values: `out_block`=0, `out_valid`=0, `out_last`=0, `in_ready`=0, `idx`=0, `pad_pending`=0.
- `in_ready` is a combinational decode of the state register: high in FILL only. It is low during reset and low for the first cycle after reset releases.
- The accept edge of the last byte or of a flush makes `out_valid` high on the next cycle. Latency is 1 cycle.
- A block is consumed on the edge where `out_valid` and `out_ready` are both high. Then `in_ready` is high the next cycle, or the pad block is valid the next cycle.
- Throughput: NB+1 cycles per full block when `out_ready` is held high. An exact-multiple message costs one extra cycle for the pad block.
- There is no combinational path from `out_ready` to `out_valid` or `out_block`.

## Test plan

- Reset low mid-fill after 5 bytes, then release → `out_valid`=0 throughout, `in_ready`=0 during reset and for 1 cycle after; next message starts at slot 0 with no stale bytes.
- "abc" (61,62,63; `in_last` on 63) → single block: slots 0-2 = 61 62 63, slot 3 = 60, slots 4-166 = 00, slot 167 = 01, `out_last`=1, `out_valid` 1 cycle after the 63 accept.
- 167 bytes of 0xAA, last on the 167th → single block: slots 0-166 = AA, slot 167 = 61, `out_last`=1.
- 168 bytes of 0x55, last on the 168th → block 1 all 55 with `out_last`=0; block 2 slot 0 = 60, slots 1-166 = 00, slot 167 = 01, `out_last`=1; exactly 2 handshakes.
- `in_flush` with no bytes → one block, slot 0 = 60, slot 167 = 01, `out_last`=1.
- Backpressure and precedence:
  - `out_ready` held low 10 cycles → `out_block` and `out_last` stable, `in_ready`=0, and the following byte (0x7E, offered during the stall) lands in slot 0 of the next message.
  - `in_valid` with `in_last`, together with `in_flush`, → flush ignored and the byte is placed.
